// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Op encoding: bit 1 selects divide, bit 0 selects the upper/remainder half of the result.
package muldiv_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMulhu = 2'b01,
        OpDivu  = 2'b10,
        OpRemu  = 2'b11
    } op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single-iteration combinational step: shift-add multiply or restoring divide.
// hi/lo hold acc_hi/acc_lo for multiply and rem/quo for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] t_lo;
    logic            fits;
    logic [XLEN-1:0] sum;
    logic            carry;

    always_comb begin
        // Partial remainder after shifting in the next dividend bit; hi[XLEN-1] is bit XLEN.
        t_lo  = {hi[XLEN-2:0], lo[XLEN-1]};
        fits  = hi[XLEN-1] | (t_lo >= operand);
        sum   = lo[0] ? alu_result : hi;
        carry = lo[0] & (alu_result < hi);

        alu_b = operand;
        if (is_div) begin
            alu_a    = t_lo;
            alu_ctrl = ALU_SUB;
            hi_next  = fits ? alu_result : t_lo;
            lo_next  = {lo[XLEN-2:0], fits};
        end else begin
            alu_a    = hi;
            alu_ctrl = ALU_ADD;
            hi_next  = {carry, sum[XLEN-1:1]};
            lo_next  = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer borrowing the shared core ALU.
// The core must route alu_a/alu_b/alu_ctrl from this block and stall while busy is high.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    state_e            state_q, state_d;
    op_e               op_q;
    logic [XLEN-1:0]   hi_q, lo_q, operand_q;
    logic [CntW-1:0]   count_q;
    logic [XLEN-1:0]   resp_data_q;

    logic              accept;
    logic              last_step;
    logic              div_zero;
    op_e               req_op_e;
    logic [XLEN-1:0]   step_alu_a, step_alu_b;
    logic [2:0]        step_alu_ctrl;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [XLEN-1:0]   step_result;

    assign req_op_e  = op_e'(req_op);
    assign accept    = req_valid & (state_q == StIdle);
    assign last_step = (count_q == CntW'(ITER - 1));
    assign div_zero  = op_is_div(req_op_e) && (req_b == '0);
    // MULHU/REMU take the upper register, MUL/DIVU the lower.
    assign step_result = op_q[0] ? step_hi : step_lo;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div     (op_is_div(op_q)),
        .hi         (hi_q),
        .lo         (lo_q),
        .operand    (operand_q),
        .alu_result (alu_result),
        .alu_a      (step_alu_a),
        .alu_b      (step_alu_b),
        .alu_ctrl   (step_alu_ctrl),
        .hi_next    (step_hi),
        .lo_next    (step_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = div_zero ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        resp_valid = (state_q == StDone);
        resp_data  = resp_data_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = ALU_ADD;
        if (state_q == StRun) begin
            alu_a    = step_alu_a;
            alu_b    = step_alu_b;
            alu_ctrl = step_alu_ctrl;
        end
    end

    // Multiply and divide both start from hi=0, lo=req_a, operand=req_b.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= OpMul;
            hi_q        <= '0;
            lo_q        <= '0;
            operand_q   <= '0;
            count_q     <= '0;
            resp_data_q <= '0;
        end else if (accept) begin
            op_q      <= req_op_e;
            hi_q      <= '0;
            lo_q      <= req_a;
            operand_q <= req_b;
            count_q   <= '0;
            if (div_zero) begin
                resp_data_q <= (req_op_e == OpDivu) ? '1 : req_a;
            end
        end else if (state_q == StRun) begin
            hi_q    <= step_hi;
            lo_q    <= step_lo;
            count_q <= count_q + CntW'(1);
            if (last_step) begin
                resp_data_q <= step_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, handshake corner cases,
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_seq;

    localparam int unsigned XLEN = 32;
    localparam int LAT_RUN = XLEN + 1;

    logic            clk;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(
        .XLEN (XLEN),
        .ITER (XLEN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Shared core ALU: combinational add/subtract.
    always_comb begin
        alu_result = (alu_ctrl == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one request, wait for the response, and complete the handshake.
    // lat counts cycles from the accept cycle to the first cycle with resp_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat, output logic alu_used);
        int guard;
        guard    = 0;
        alu_used = 1'b0;
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", {63'd0, req_ready}, 64'd1);
        alu_used = (alu_a != 0) || (alu_b != 0) || (alu_ctrl != 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            alu_used = alu_used || (alu_a != 0) || (alu_b != 0) || (alu_ctrl != 0);
            @(negedge clk);
            lat++;
        end
        alu_used   = alu_used || (alu_a != 0) || (alu_b != 0) || (alu_ctrl != 0);
        data       = resp_data;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] data;
    int          lat;
    logic        used;
    int          bad;
    int          guard;

    initial begin
        vecs[0] = '{"mul_7x6",       2'b00, 32'd7,          32'd6,          32'h0000_002A, 33};
        vecs[1] = '{"mulhu_7x6",     2'b01, 32'd7,          32'd6,          32'h0000_0000, 33};
        vecs[2] = '{"mul_max",       2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33};
        vecs[3] = '{"mulhu_max",     2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33};
        vecs[4] = '{"divu_100_7",    2'b10, 32'd100,        32'd7,          32'h0000_000E, 33};
        vecs[5] = '{"remu_100_7",    2'b11, 32'd100,        32'd7,          32'h0000_0002, 33};
        vecs[6] = '{"divu_max_1",    2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 33};
        vecs[7] = '{"remu_5_msb",    2'b11, 32'd5,          32'h8000_0000,  32'h0000_0005, 33};
        vecs[8] = '{"divu_by_zero",  2'b10, 32'd123,        32'd0,          32'hFFFF_FFFF, 1};
        vecs[9] = '{"remu_by_zero",  2'b11, 32'd123,        32'd0,          32'h0000_007B, 1};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        #12;
        chk("rst_busy",       {63'd0, busy},       64'd0);
        chk("rst_req_ready",  {63'd0, req_ready},  64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data",  {32'd0, resp_data},  64'd0);
        chk("rst_alu_a",      {32'd0, alu_a},      64'd0);
        chk("rst_alu_b",      {32'd0, alu_b},      64'd0);
        chk("rst_alu_ctrl",   {61'd0, alu_ctrl},   64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, lat, used);
            chk({vecs[i].name, "_data"}, {32'd0, data}, {32'd0, vecs[i].exp});
            chk({vecs[i].name, "_lat"},  64'(lat),      64'(vecs[i].lat));
            // The divide-by-zero shortcut must never drive the shared ALU.
            chk({vecs[i].name, "_alu_used"}, {63'd0, used},
                {63'd0, !(vecs[i].op[1] && vecs[i].b == 0)});
        end

        // Backpressure in DONE while a second request is held pending.
        @(negedge clk);
        req_op = 2'b00; req_a = 32'd7; req_b = 32'd6; req_valid = 1'b1;
        @(negedge clk);
        req_a = 32'd3; req_b = 32'd5;
        bad   = 0;
        guard = 0;
        while (!resp_valid && guard < 100) begin
            if (req_ready) bad++;
            @(negedge clk);
            guard++;
        end
        chk("bp_ready_low_run", 64'(bad), 64'd0);
        chk("bp_first_data", {32'd0, resp_data}, 64'h2A);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== 32'h2A || req_ready) bad++;
        end
        chk("bp_hold_stable", 64'(bad), 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_bubble_idle", {61'd0, busy, req_ready, resp_valid}, {61'd0, 3'b010});
        @(negedge clk);
        chk("bp_accepted", {63'd0, busy}, 64'd1);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_lat",  64'(lat), 64'(LAT_RUN));
        chk("bp_second_data", {32'd0, resp_data}, 64'd15);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        req_op = 2'b00; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_pre_busy", {63'd0, busy}, 64'd1);
        chk("midrst_pre_alu_b", {32'd0, alu_b}, 64'd5);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",       {63'd0, busy},       64'd0);
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_req_ready",  {63'd0, req_ready},  64'd1);
        chk("midrst_alu", {alu_a != 0, alu_b != 0, alu_ctrl != 0}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'b00, 32'd3, 32'd5, data, lat, used);
        chk("post_rst_mul_data", {32'd0, data}, 64'd15);
        chk("post_rst_mul_lat",  64'(lat),      64'(LAT_RUN));

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          mode;
            op   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            a    = $urandom;
            b    = $urandom;
            if (mode == 1) begin
                a = $urandom_range(0, 1000);
                b = $urandom_range(1, 40);
            end else if (mode == 2) begin
                b = (i % 2 == 0) ? 32'd0 : 32'd1;
            end else if (mode == 3) begin
                a = a | 32'h8000_0000;
                b = b >> $urandom_range(0, 31);
            end
            run_op(op, a, b, data, lat, used);
            chk("rand_data", {32'd0, data}, {32'd0, model(op, a, b)});
            chk("rand_lat", 64'(lat), (op[1] && b == 0) ? 64'd1 : 64'(LAT_RUN));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
